// File: rtl/fifo_unpacker.sv
// Pops WIDTH-bit words from the shift-register FIFO and streams them out as
// WIDTH/OUT_WIDTH narrow beats on a valid/ready interface, LSB beat first.
module fifo_unpacker #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_shift_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [15:0]          word_count
);

  localparam int unsigned N          = WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(N - 2);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [WIDTH-1:0]       shreg, shreg_n;
  logic                   out_valid_n;
  logic [OUT_WIDTH-1:0]   out_data_n;
  logic                   out_last_n;
  logic [15:0]            word_count_n;
  logic                   accept;
  logic                   at_last;
  logic                   pop;
  logic [WIDTH-1:0]       shifted;

  // The pop strobe doubles as the FIFO's shift_out, so the head word is
  // captured and consumed on the same edge.
  assign accept         = out_valid & out_ready;
  assign at_last        = (idx == IDX_LAST);
  assign pop            = enable & ~fifo_empty & ~res &
                          ((state == IDLE) | ((state == SEND) & accept & at_last));
  assign fifo_shift_out = pop;
  assign shifted        = shreg >> OUT_WIDTH;

  // Next-state and registered-output logic.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    shreg_n      = shreg;
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    out_last_n   = out_last;
    word_count_n = word_count;

    case (state)
      IDLE: begin
        if (pop) begin
          state_n     = SEND;
          idx_n       = '0;
          shreg_n     = fifo_data;
          out_valid_n = 1'b1;
          out_data_n  = fifo_data[OUT_WIDTH-1:0];
          out_last_n  = 1'b0;
        end
      end
      SEND: begin
        if (accept) begin
          if (!at_last) begin
            idx_n      = idx + IDX_W'(1);
            shreg_n    = shifted;
            out_data_n = shifted[OUT_WIDTH-1:0];
            out_last_n = (idx == IDX_PENULT);
          end else begin
            word_count_n = word_count + 16'd1;
            if (pop) begin
              // Next word loads on the final-beat edge: no bubble.
              idx_n       = '0;
              shreg_n     = fifo_data;
              out_valid_n = 1'b1;
              out_data_n  = fifo_data[OUT_WIDTH-1:0];
              out_last_n  = 1'b0;
            end else begin
              state_n     = IDLE;
              out_valid_n = 1'b0;
              out_last_n  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_last   <= out_last_n;
      word_count <= word_count_n;
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Randomized scoreboard bench for fifo_unpacker: words pushed into a model FIFO
// are queued as expected output; a negedge monitor checks beats, pops and count.
module tb_fifo_unpacker;

  localparam int unsigned W  = 64;
  localparam int unsigned OW = 16;
  localparam int unsigned N  = W / OW;

  logic          clk;
  logic          res;
  logic          enable;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_shift_out;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [15:0]   word_count;

  fifo_unpacker #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk           (clk),
    .res           (res),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_shift_out(fifo_shift_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_words[$];

  int total = 0;
  int bad   = 0;
  int preload_seq = 0;
  int timeout_seq = 0;

  // Monitor-owned model state.
  logic         armed = 1'b0;
  logic         prev_res = 1'b0;
  logic [15:0]  exp_cnt = 16'd0;
  int           beats_left = 0;
  logic [W-1:0] cur_word = '0;
  int           seen_preload = 0;
  int           seen_timeout = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic [W-1:0]  sl;
    logic          exp_pop;
    if (res) armed = 1'b1;
    if (armed) begin
      if (preload_seq != seen_preload) begin
        seen_preload = preload_seq;
        exp_cnt = 16'hFFFE;
      end
      if (timeout_seq != seen_timeout) begin
        seen_timeout = timeout_seq;
        total++;
        bad++;
        $display("FAIL drain_timeout: got pending work expected idle at %0t", $time);
      end
      check("word_count", 64'(word_count), 64'(exp_cnt));
      check("out_valid", 64'(out_valid), 64'(beats_left != 0));
      if (prev_res) begin
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
      end
      if (res) begin
        check("pop_during_reset", 64'(fifo_shift_out), 64'd0);
        beats_left = 0;
        exp_cnt = 16'd0;
      end else begin
        if (beats_left != 0) begin
          sl = cur_word >> (OW * (N - beats_left));
          check("out_data", 64'(out_data), 64'(sl[OW-1:0]));
          check("out_last", 64'(out_last), 64'(beats_left == 1));
          if (out_ready) begin
            beats_left--;
            if (beats_left == 0) exp_cnt = exp_cnt + 16'd1;
          end
        end
        exp_pop = enable && (exp_words.size() != 0) && (beats_left == 0);
        check("fifo_shift_out", 64'(fifo_shift_out), 64'(exp_pop));
        if (exp_pop) begin
          cur_word = exp_words.pop_front();
          beats_left = N;
        end
      end
      prev_res = res;
    end
  end

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_words.push_back(w);
  endtask

  // One clock: apply inputs after the rising edge, let the FIFO react to shift_out.
  task automatic step(input logic en, input logic rdy, input logic rs);
    logic popped;
    enable     = en;
    out_ready  = rdy;
    res        = rs;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : {$urandom, $urandom};
    @(negedge clk);
    #1;
    popped = fifo_shift_out;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || out_valid) && n < 400) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (n >= 400) timeout_seq++;
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    res        = 1'b1;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Empty FIFO with enable high, then a word held off by enable low.
    repeat (4) step(1'b1, 1'b1, 1'b0);
    push_word(64'h4444_3333_2222_1111);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Single word, ready held high.
    repeat (8) step(1'b1, 1'b1, 1'b0);

    // Three words back-to-back.
    push_word(64'hAAAA_BBBB_CCCC_DDDD);
    push_word(64'h0123_4567_89AB_CDEF);
    push_word(64'hFFFF_0000_FFFF_0000);
    repeat (16) step(1'b1, 1'b1, 1'b0);

    // Backpressure during beat 2 with another word waiting.
    push_word(64'h4444_3333_2222_1111);
    push_word(64'h5555_6666_7777_8888);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    drain();

    // Enable dropped mid-word: the word completes, the next stays queued.
    push_word(64'h1357_9BDF_2468_ACE0);
    push_word(64'hDEAD_BEEF_CAFE_F00D);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1, 1'b0);
    drain();

    // Reset after beat 1 is accepted; the following word starts from beat 0.
    push_word(64'h9999_8888_7777_6666);
    push_word(64'h0F0F_1E1E_2D2D_3C3C);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    drain();

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) push_word({$urandom, $urandom});
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end
    drain();

    // Counter wrap: preload near the top, then deliver two words.
    force dut.word_count = 16'hFFFE;
    #1;
    release dut.word_count;
    preload_seq++;
    push_word(64'h1111_2222_3333_4444);
    push_word(64'h5555_6666_7777_8888);
    drain();
    repeat (2) step(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Read-side consumer for the shift-register FIFO. It pops WIDTH-bit words from the FIFO head and emits each word as WIDTH/OUT_WIDTH narrower beats on a valid/ready stream, least-significant beat first. It sits between the FIFO's `data_out`/`empty`/`shift_out` pins and a narrow downstream sink, such as a serial link or bus master. It supports back-to-back words with no bubble cycles and full downstream backpressure.

## Interface
- `WIDTH`, 64, FIFO word width; must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 16, output beat width; N = WIDTH/OUT_WIDTH, N ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `res`  in  1  reset: synchronous, active-high.
- `enable`  in  1  permits popping new words; does not stop a word already in flight.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  WIDTH  FIFO head word (`data_out`), valid whenever `fifo_empty`=0.
- `fifo_shift_out`  out  1  pop strobe to the FIFO `shift_out` pin (combinational).
- `out_valid`  out  1  beat valid (registered).
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  OUT_WIDTH  current beat (registered).
- `out_last`  out  1  current beat is beat N-1 of its word (registered).
- `word_count`  out  16  words fully delivered, mod 2^16.

## Operation
- States:
  - IDLE: no word held.
  - SEND: a word is held; beat index `idx` runs 0..N-1.
- Pop condition `pop` = `enable` & ~`fifo_empty` & ~`res` & (IDLE | (SEND & `out_valid` & `out_ready` & `idx`==N-1)).
- `fifo_shift_out` = `pop`. It is never asserted outside this condition, and never on an empty FIFO.
- On a `pop` edge:
  - `fifo_data` is captured into the WIDTH-bit shift register.
  - `idx` ← 0; state ← SEND; `out_valid` ← 1.
  - `out_data` ← `fifo_data[OUT_WIDTH-1:0]`.
  - `out_last` ← 0.
- Accepted beat (`out_valid` & `out_ready`) with `idx` < N-1:
  - shift register shifts right by OUT_WIDTH; `idx` ← `idx`+1.
  - `out_data` ← next slice.
  - `out_last` ← (`idx`+1 == N-1).
- Accepted beat with `idx` == N-1:
  - `word_count` increments, wrapping 0xFFFF→0x0000.
  - If `pop`, the next word loads on the same edge: no bubble.
  - Otherwise state ← IDLE, `out_valid` ← 0, `out_last` ← 0.
- `out_valid`=1 & `out_ready`=0: `out_data`, `out_last`, `idx` and the shift register all hold. A valid beat is never withdrawn or altered until it is accepted.
- `enable` low: the current word completes normally, then the block idles. No pop occurs while `enable`=0.
- `out_data` holds its last value in IDLE and is don't-care for the sink.

## Timing
- Reset (`res`=1 at an edge):
  - state IDLE, `idx` 0, shift register 0.
  - `out_valid` 0, `out_data` 0, `out_last` 0, `word_count` 0.
  - `fifo_shift_out` is forced 0 in any cycle where `res`=1.
- Reset mid-word: the partially sent word is discarded, not re-popped, and `word_count` does not include it. Popping resumes in the first cycle after `res` falls.
- Latency: `fifo_shift_out` is high in cycle T (IDLE, FIFO non-empty); beat 0 appears with `out_valid` in cycle T+1.
- Throughput: with `out_ready` held at 1, there is one beat per cycle and N cycles per word, continuous across words.
- FIFO coupling: the FIFO pops at the same edge where the unpacker captures `fifo_data`, so the head word is consumed exactly once.
- A FIFO that becomes empty during SEND has no effect until the word's final beat is accepted.

## Test plan
- Single word: WIDTH=64, OUT_WIDTH=16, FIFO holds 0x4444_3333_2222_1111, `out_ready`=1 -> beats 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; `out_last` only on 0x4444; one `fifo_shift_out` pulse; `word_count`=1; then IDLE with `out_valid`=0.
- Back-to-back: 3 words preloaded, `out_ready`=1 -> 12 consecutive valid beats with no gap; `fifo_shift_out` pulses in the same cycles as beats 4 and 8 are accepted, plus the initial pop; `word_count`=3.
- Backpressure: `out_ready` low for 5 cycles during beat 2 -> `out_data`=0x3333 and `out_valid`=1 stable throughout; no pop; sequence resumes intact.
- Empty/enable: FIFO empty, or `enable`=0 with FIFO non-empty -> `fifo_shift_out` stays 0 and `out_valid` stays 0. `enable` dropped mid-word -> that word finishes and no further pop occurs.
- Reset mid-word: `res` pulsed after beat 1 is accepted -> next cycle all outputs are 0 and `word_count`=0; the next FIFO word is then popped and delivered from beat 0.
- Counter wrap: force 65536 single-beat-accepted words (or preload the counter in the bench) -> `word_count` reads 0xFFFF, then 0x0000.
